fp_normalizer: RTL and testbench

Post-add normalize/round/pack stage of the single-precision FP adder. Accepts the raw sign, common exponent and extended-width mantissa sum from the add stage, which follows the exponent-difference and fraction-alignment steps. Normalizes iteratively, one bit per cycle, then rounds to nearest-even and packs an IEEE-754 binary32 word. Uses a valid/ready handshake on both sides.

---
 rtl/fp_normalizer.sv | 154 +++++++++++++++
 tb/tb_fp_normalizer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Post-add normalize/round/pack stage of the binary32 adder: shifts the raw mantissa sum one bit
// per cycle until normalized, rounds to nearest-even and packs the result word.
module fp_normalizer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [26:0] mant_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e      st_q, st_d;
    logic [26:0] mant_q, mant_d;
    logic [8:0]  exp_q, exp_d;
    logic        sgn_q, sgn_d;
    logic        den_q, den_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic        rnd_up;
    logic [24:0] rnd_m;
    logic [8:0]  rnd_exp;
    logic [7:0]  rnd_field;
    logic [22:0] rnd_frac;
    logic        rnd_ovf;
    logic        rnd_unf;

    // Round-to-nearest-even on the normalized mantissa, plus carry and denormal fix-ups.
    always_comb begin
        rnd_up    = mant_q[1] & (mant_q[0] | mant_q[2]);
        rnd_m     = {1'b0, mant_q[25:2]} + {24'd0, rnd_up};
        rnd_exp   = exp_q;
        rnd_frac  = rnd_m[22:0];
        rnd_ovf   = 1'b0;
        rnd_unf   = 1'b0;
        if (rnd_m[24]) begin
            rnd_exp  = exp_q + 9'd1;
            rnd_frac = rnd_m[23:1];
        end
        rnd_field = rnd_exp[7:0];
        if (den_q) begin
            // A denormal that rounds up into the hidden bit becomes the smallest normal.
            if (rnd_m[23]) begin
                rnd_field = 8'd1;
            end else begin
                rnd_field = 8'd0;
                rnd_unf   = 1'b1;
            end
        end else if (rnd_exp >= 9'd255) begin
            rnd_field = 8'hFF;
            rnd_frac  = 23'd0;
            rnd_ovf   = 1'b1;
        end
    end

    always_comb begin
        st_d        = st_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        sgn_d       = sgn_q;
        den_d       = den_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        unique case (st_q)
            StIdle: begin
                if (in_valid) begin
                    sgn_d  = sign_in;
                    mant_d = mant_in;
                    exp_d  = (exp_in == 8'd0) ? 9'd1 : {1'b0, exp_in};
                    den_d  = 1'b0;
                    st_d   = StNorm;
                end
            end
            StNorm: begin
                if (mant_q == 27'd0) begin
                    result_d    = {sgn_q, 31'd0};
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    out_valid_d = 1'b1;
                    st_d        = StDone;
                end else if (mant_q[26]) begin
                    // Right shift keeps the dropped bit folded into sticky.
                    mant_d = {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 9'd1;
                end else if (mant_q[25]) begin
                    st_d = StRound;
                end else if (exp_q == 9'd1) begin
                    den_d = 1'b1;
                    st_d  = StRound;
                end else begin
                    mant_d = {mant_q[25:0], 1'b0};
                    exp_d  = exp_q - 9'd1;
                end
            end
            StRound: begin
                result_d    = {sgn_q, rnd_field, rnd_frac};
                overflow_d  = rnd_ovf;
                underflow_d = rnd_unf;
                out_valid_d = 1'b1;
                st_d        = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    st_d        = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q        <= StIdle;
            mant_q      <= 27'd0;
            exp_q       <= 9'd0;
            sgn_q       <= 1'b0;
            den_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            sgn_q       <= sgn_d;
            den_q       <= den_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign in_ready  = (st_q == StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Bench for fp_normalizer: directed corner vectors plus random operands against an arithmetic model.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = 8'd0;
    logic [26:0] mant_in = 27'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int n_vec = 0;
    int n_err = 0;

    fp_normalizer dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Reference: locate the leading one, shift as far as the exponent allows, then round
    // the integer significand with the two extra bits as a remainder.
    function automatic void model(input bit s, input logic [7:0] ei, input logic [26:0] mi,
                                  output logic [31:0] r, output bit ov, output bit uf,
                                  output int lat);
        logic [63:0] m;
        logic [63:0] q;
        int e, p, sh;
        bit den, up;
        m  = {37'd0, mi};
        e  = (ei == 8'd0) ? 1 : int'(ei);
        ov = 1'b0;
        uf = 1'b0;
        if (mi == 27'd0) begin
            r   = {s, 31'd0};
            lat = 1;
            return;
        end
        p = -1;
        for (int i = 0; i < 27; i++) if (mi[i]) p = i;
        sh = 0;
        if (p == 26) begin
            m = (m >> 1) | (m & 64'd1);
            e = e + 1;
            lat = 3;
        end else begin
            sh = 25 - p;
            if (sh > e - 1) sh = e - 1;
            m = m << sh;
            e = e - sh;
            lat = 2 + sh;
        end
        den = (m[25] == 1'b0);
        q   = m >> 2;
        up  = (m[1:0] == 2'b11) || (m[1:0] == 2'b10 && q[0]);
        q   = q + {63'd0, up};
        if (q == 64'd1 << 24) begin
            q = q >> 1;
            e = e + 1;
        end
        if (den) begin
            r  = {s, (q[23] ? 8'd1 : 8'd0), q[22:0]};
            uf = !q[23];
        end else if (e >= 255) begin
            r  = {s, 8'hFF, 23'd0};
            ov = 1'b1;
        end else begin
            r = {s, 8'(e), q[22:0]};
        end
    endfunction

    task automatic apply_op(input bit s, input logic [7:0] e, input logic [26:0] m,
                            output logic [31:0] r, output logic ov, output logic uf,
                            output int lat);
        sign_in  = s;
        exp_in   = e;
        mant_in  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = result;
        ov = overflow;
        uf = underflow;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if (out_valid !== 1'b0 || result !== 32'd0 || overflow !== 1'b0 || underflow !== 1'b0
            || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: got ov=%b res=%h of=%b uf=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, result, overflow, underflow, in_ready);
        end
    endtask

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [26:0] m;
        logic [31:0] r;
        logic        ov;
        logic        uf;
        logic [5:0]  lat;
    } dir_t;

    task automatic test_directed();
        dir_t vecs[8];
        logic [31:0] r;
        logic ov, uf;
        int lat;
        vecs[0] = '{1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 6'd3};
        vecs[1] = '{1'b0, 8'd130, 27'h0800000, 32'h40000000, 1'b0, 1'b0, 6'd4};
        vecs[2] = '{1'b0, 8'd127, 27'h2000006, 32'h3F800002, 1'b0, 1'b0, 6'd2};
        vecs[3] = '{1'b0, 8'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b0, 6'd2};
        vecs[4] = '{1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 1'b0, 1'b0, 6'd2};
        vecs[5] = '{1'b0, 8'd254, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 6'd3};
        vecs[6] = '{1'b1, 8'd127, 27'h0000000, 32'h80000000, 1'b0, 1'b0, 6'd1};
        vecs[7] = '{1'b0, 8'd2,   27'h0800000, 32'h00400000, 1'b0, 1'b1, 6'd3};
        for (int i = 0; i < 8; i++) begin
            apply_op(vecs[i].s, vecs[i].e, vecs[i].m, r, ov, uf, lat);
            n_vec++;
            if (r !== vecs[i].r || ov !== vecs[i].ov || uf !== vecs[i].uf
                || lat != int'(vecs[i].lat)) begin
                n_err++;
                $display("FAIL directed[%0d]: got res=%h of=%b uf=%b lat=%0d, want %h %b %b %0d",
                         i, r, ov, uf, lat, vecs[i].r, vecs[i].ov, vecs[i].uf, vecs[i].lat);
            end
            accept();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL handshake[%0d]: got ov=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er;
        logic ov, uf;
        bit eov, euf;
        int lat, elat, nb;
        bit s;
        logic [7:0] e;
        logic [26:0] m, mask;
        for (int i = 0; i < 300; i++) begin
            s    = 1'($urandom);
            nb   = $urandom_range(0, 27);
            mask = 27'((64'd1 << nb) - 64'd1);
            m    = 27'($urandom) & mask;
            case ($urandom_range(0, 2))
                0: e = 8'($urandom_range(0, 30));
                1: e = 8'($urandom_range(240, 255));
                default: e = 8'($urandom_range(0, 255));
            endcase
            model(s, e, m, er, eov, euf, elat);
            apply_op(s, e, m, r, ov, uf, lat);
            n_vec++;
            if (r !== er || ov !== eov || uf !== euf || lat != elat) begin
                n_err++;
                $display("FAIL random[%0d] s=%b e=%0d m=%h: got res=%h of=%b uf=%b lat=%0d, want %h %b %b %0d",
                         i, s, e, m, r, ov, uf, lat, er, eov, euf, elat);
            end
            accept();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic ov, uf;
        int lat;
        apply_op(1'b0, 8'd127, 27'h2000006, r, ov, uf, lat);
        in_valid = 1'b1;
        sign_in  = 1'b1;
        exp_in   = 8'd5;
        mant_in  = 27'h0000100;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (result !== 32'h3F800002 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure[%0d]: got res=%h ov=%b rdy=%b, want 3f800002 1 0",
                         i, result, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        accept();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h3F800002) begin
            n_err++;
            $display("FAIL bp_release: got ov=%b rdy=%b res=%h, want 0 1 3f800002",
                     out_valid, in_ready, result);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, er;
        logic ov, uf;
        bit eov, euf, seen;
        int lat, elat;
        sign_in  = 1'b0;
        exp_in   = 8'd200;
        mant_in  = 27'h0000001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL busy: got rdy=%b ov=%b, want 0 0", in_ready, out_valid);
        end
        rstn = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1
            || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got ov=%b res=%h rdy=%b of=%b uf=%b, want 0 0 1 0 0",
                     out_valid, result, in_ready, overflow, underflow);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_discard: got out_valid=1 after reset, want 0");
        end
        model(1'b1, 8'd10, 27'h0012345, er, eov, euf, elat);
        apply_op(1'b1, 8'd10, 27'h0012345, r, ov, uf, lat);
        n_vec++;
        if (r !== er || ov !== eov || uf !== euf || lat != elat) begin
            n_err++;
            $display("FAIL post_reset: got res=%h of=%b uf=%b lat=%0d, want %h %b %b %0d",
                     r, ov, uf, lat, er, eov, euf, elat);
        end
        accept();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rstn = 1'b1;
        @(posedge clk);
        #1;
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
